// File: rtl/mux_pkg.sv
// Shared definitions for the mux/arbiter family.
// The run-time mode encoding is kept here so that later selectors can reuse it.
package mux_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

endpackage

// File: rtl/mux_arb_n_rr_pick.sv
// Rotate-priority search: the first set request after ptr, wrapping modulo N.
// This block is purely combinational; the caller owns the pointer register.
module rr_pick #(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int idx;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    // Walk ptr+1 .. ptr+N. The first hit wins, so the channel at ptr itself is considered last.
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel registered selector with a valid/ready handshake.
// It runs in either DIRECT (explicit sel) or round-robin mode and has a single output stage.
module mux_arb_n
  import mux_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_src,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_data_reg;
  logic [SEL_W-1:0] out_src_reg;
  logic             out_valid_reg;
  logic [SEL_W-1:0] rr_ptr_reg;

  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;
  logic             direct_hit;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_any;
  logic             is_rr;
  logic             load_en;
  logic             accept;

  rr_pick #(.N(N)) u_rr_pick (
    .req     (in_valid),
    .ptr     (rr_ptr_reg),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  assign is_rr = (mode_e'(mode) == MODE_RR);

  // An out-of-range sel never grants, even when N is not a power of two.
  always_comb begin
    direct_hit = 1'b0;
    if (int'(sel) < N) begin
      direct_hit = in_valid[sel];
    end
  end

  assign grant_idx = is_rr ? rr_idx : sel;
  assign grant_any = is_rr ? rr_any : direct_hit;

  // The enable is held low during reset, so no channel sees ready while the stage is being cleared.
  assign load_en = rst_n && (!out_valid_reg || out_ready);
  assign accept  = load_en && grant_any;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign in_ready[gi] = accept && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_src_reg   <= '0;
      rr_ptr_reg    <= SEL_W'(N - 1);
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= in_data[32'(grant_idx)*WIDTH +: WIDTH];
      out_src_reg   <= grant_idx;
      if (is_rr) begin
        rr_ptr_reg <= grant_idx;
      end
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: a table of per-cycle vectors on a 4-channel instance,
// plus hand-written sequences on a 3-channel instance and for a reset in the middle of a stream.
module tb_mux_arb_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 4-channel, 64-bit instance
  logic [255:0] d4_in_data;
  logic [3:0]   d4_in_valid;
  logic [3:0]   d4_in_ready;
  logic         d4_mode;
  logic [1:0]   d4_sel;
  logic [63:0]  d4_out_data;
  logic [1:0]   d4_out_src;
  logic         d4_out_valid;
  logic         d4_out_ready;

  // 3-channel, 16-bit instance
  logic [47:0]  d3_in_data;
  logic [2:0]   d3_in_valid;
  logic [2:0]   d3_in_ready;
  logic         d3_mode;
  logic [1:0]   d3_sel;
  logic [15:0]  d3_out_data;
  logic [1:0]   d3_out_src;
  logic         d3_out_valid;
  logic         d3_out_ready;

  mux_arb_n #(.WIDTH(64), .N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4_in_data), .in_valid(d4_in_valid),
    .in_ready(d4_in_ready), .mode(d4_mode), .sel(d4_sel), .out_data(d4_out_data),
    .out_src(d4_out_src), .out_valid(d4_out_valid), .out_ready(d4_out_ready)
  );

  mux_arb_n #(.WIDTH(16), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_valid(d3_in_valid),
    .in_ready(d3_in_ready), .mode(d3_mode), .sel(d3_sel), .out_data(d3_out_data),
    .out_src(d3_out_src), .out_valid(d3_out_valid), .out_ready(d3_out_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_valid;
    logic [1:0]  exp_src;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[18];

  localparam logic [63:0] D0 = 64'h0000_0000_0000_00A0;
  localparam logic [63:0] D1 = 64'h0000_0000_0000_00A1;
  localparam logic [63:0] D2 = 64'h0000_0000_DEAD_BEEF;
  localparam logic [63:0] D3 = 64'h0000_0000_0000_00A3;

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // The state before row 0 is out_valid=0 and rr_ptr=3 (the reset value).
    vecs[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, D2}; // DIRECT load
    vecs[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0}; // RR fairness x8
    vecs[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
    vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
    vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, D3};
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
    vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
    vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
    vecs[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, D3};
    vecs[9]  = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, D3}; // stall x3
    vecs[10] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, D3};
    vecs[11] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, D3};
    vecs[12] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0}; // release: drain+load
    vecs[13] = '{1'b0, 2'd1, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0, D0}; // drain only, no grant
    vecs[14] = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, D3}; // DIRECT load into empty
    vecs[15] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, D1}; // ptr unchanged by DIRECT
    vecs[16] = '{1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, D1}; // hold
    vecs[17] = '{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, D1}; // drain, hold data/src

    d4_in_data   = {D3, D2, D1, D0};
    d3_in_data   = {16'h0B02, 16'h0B01, 16'h0B00};
    d4_mode      = 1'b1;
    d4_sel       = 2'd0;
    d4_in_valid  = 4'b1111;
    d4_out_ready = 1'b1;
    d3_mode      = 1'b1;
    d3_sel       = 2'd0;
    d3_in_valid  = 3'b111;
    d3_out_ready = 1'b1;

    // Reset for 2 cycles with every channel valid.
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("reset_in_ready", 64'(d4_in_ready), 64'h0);
      check("reset_in_ready3", 64'(d3_in_ready), 64'h0);
      @(posedge clk); #1;
      check("reset_out_valid", 64'(d4_out_valid), 64'h0);
      check("reset_out_data", d4_out_data, 64'h0);
      check("reset_out_src", 64'(d4_out_src), 64'h0);
      check("reset_out_valid3", 64'(d3_out_valid), 64'h0);
      $display("reset cycle %0d: out_valid=%0b out_data=%h in_ready=%b",
               c, d4_out_valid, d4_out_data, d4_in_ready);
    end
    rst_n = 1'b1;
    d3_in_valid = 3'b000;

    for (int v = 0; v < 18; v++) begin
      d4_mode      = vecs[v].mode;
      d4_sel       = vecs[v].sel;
      d4_in_valid  = vecs[v].iv;
      d4_out_ready = vecs[v].ordy;
      #1;
      check($sformatf("vec%0d_in_ready", v), 64'(d4_in_ready), 64'(vecs[v].exp_rdy));
      @(posedge clk); #1;
      check($sformatf("vec%0d_out_valid", v), 64'(d4_out_valid), 64'(vecs[v].exp_valid));
      check($sformatf("vec%0d_out_src", v), 64'(d4_out_src), 64'(vecs[v].exp_src));
      check($sformatf("vec%0d_out_data", v), d4_out_data, vecs[v].exp_data);
      $display("vec %0d: mode=%0b sel=%0d iv=%b ordy=%0b -> in_ready=%b out_valid=%0b src=%0d data=%h",
               v, vecs[v].mode, vecs[v].sel, vecs[v].iv, vecs[v].ordy,
               d4_in_ready, d4_out_valid, d4_out_src, d4_out_data);
    end
    d4_in_valid = 4'b0000;

    // N=3: sel=3 is out of range and must never grant.
    d3_mode = 1'b0; d3_sel = 2'd3; d3_in_valid = 3'b111; d3_out_ready = 1'b1;
    #1;
    check("n3_sel3_in_ready", 64'(d3_in_ready), 64'h0);
    @(posedge clk); #1;
    check("n3_sel3_out_valid", 64'(d3_out_valid), 64'h0);
    $display("n3 sel=3: in_ready=%b out_valid=%0b", d3_in_ready, d3_out_valid);

    // N=3 RR with only channel 1 requesting: it wins every cycle.
    d3_mode = 1'b1; d3_in_valid = 3'b010;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("n3_rr1_in_ready", 64'(d3_in_ready), 64'h2);
      @(posedge clk); #1;
      check("n3_rr1_out_valid", 64'(d3_out_valid), 64'h1);
      check("n3_rr1_out_src", 64'(d3_out_src), 64'h1);
      check("n3_rr1_out_data", 64'(d3_out_data), 64'h0B01);
      $display("n3 rr only ch1 cycle %0d: src=%0d data=%h", c, d3_out_src, d3_out_data);
    end
    // With rr_ptr=1 the next picks are 2, then 0 (wrap at N=3), then 1.
    d3_in_valid = 3'b111;
    for (int c = 0; c < 3; c++) begin
      automatic logic [1:0] exp_src = (c == 0) ? 2'd2 : (c == 1) ? 2'd0 : 2'd1;
      @(posedge clk); #1;
      check("n3_rr_wrap_src", 64'(d3_out_src), 64'(exp_src));
      check("n3_rr_wrap_data", 64'(d3_out_data), 64'(16'h0B00 + 16'(exp_src)));
      $display("n3 rr all cycle %0d: src=%0d data=%h", c, d3_out_src, d3_out_data);
    end
    d3_in_valid = 3'b000;

    // Reset in the middle of a stream: the held word is dropped and RR restarts at channel 0.
    // dut4 rr_ptr is currently 1; load channel 2 and stall.
    d4_mode = 1'b1; d4_in_valid = 4'b0100; d4_out_ready = 1'b0;
    @(posedge clk); #1;
    check("midrst_loaded_src", 64'(d4_out_src), 64'h2);
    check("midrst_loaded_valid", 64'(d4_out_valid), 64'h1);
    d4_in_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(d4_in_ready), 64'h0);
    @(posedge clk); #1;
    check("midrst_out_valid", 64'(d4_out_valid), 64'h0);
    check("midrst_out_data", d4_out_data, 64'h0);
    $display("mid-stream reset: out_valid=%0b out_data=%h", d4_out_valid, d4_out_data);
    rst_n = 1'b1; d4_out_ready = 1'b1;
    #1;
    check("midrst_restart_ready", 64'(d4_in_ready), 64'h1);
    @(posedge clk); #1;
    check("midrst_restart_src", 64'(d4_out_src), 64'h0);
    check("midrst_restart_data", d4_out_data, D0);
    $display("after reset: src=%0d data=%h", d4_out_src, d4_out_data);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
